netlist_comment_stripper: RTL



---
 rtl/netlist_rd_pkg.sv | 25 ++
 rtl/strip_out_fifo.sv | 62 ++++++
 rtl/netlist_comment_stripper.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/netlist_rd_pkg.sv
// Shared definitions for the netlist reader front-end: comment-stripper
// state encoding, ASCII constants and the default statistics width.
package netlist_rd_pkg;

    typedef enum logic [2:0] {
        CODE       = 3'd0,
        SLASH      = 3'd1,
        LINE_C     = 3'd2,
        BLOCK_C    = 3'd3,
        BLOCK_STAR = 3'd4
    } strip_state_t;

    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_SP    = 8'h20;

    localparam int CNT_W_DEFAULT = 16;

    // Build a FIFO entry: bit 8 marks the final byte of a file.
    function automatic logic [8:0] make_entry(input logic last, input logic [7:0] data);
        return {last, data};
    endfunction

endpackage

// File: rtl/strip_out_fifo.sv
// Output buffer for the comment stripper: DEPTH x {last, data} entries.
// Two write lanes (push1 is only ever used together with push0), one read
// lane with the head entry presented directly on dout, and a free-entry
// count so the producer can tell whether a two-byte emission fits.
module strip_out_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push0,
    input  logic          push1,
    input  logic [8:0]    din0,
    input  logic [8:0]    din1,
    input  logic          pop,
    output logic [8:0]    dout,
    output logic          not_empty,
    output logic [AW:0]   free
);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   n_push;
    logic [AW-1:0] wr_ptr_p1;

    // Number of entries written this cycle and the second write slot.
    always_comb begin
        n_push    = (AW+1)'(push0) + (AW+1)'(push1);
        wr_ptr_p1 = wr_ptr + AW'(1);
    end

    // Storage, pointers and occupancy; memory is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push0) begin
                mem[wr_ptr] <= din0;
            end
            if (push1) begin
                mem[wr_ptr_p1] <= din1;
            end
            wr_ptr <= wr_ptr + n_push[AW-1:0];
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + n_push - (AW+1)'(pop);
        end
    end

    assign dout      = mem[rd_ptr];
    assign not_empty = (count != '0);
    assign free      = (AW+1)'(DEPTH) - count;

endmodule

// File: rtl/netlist_comment_stripper.sv
// Removes // and /* */ comments from a netlist byte stream.
// Input and output use valid/ready: a beat transfers on the rising clock
// edge where valid and ready are both high; the sender holds valid, data and
// last stable until that edge, and ready never depends on the same-side valid.
// Optional statistics counters are built when COMMENT_STATS_EN is defined;
// otherwise comment_cnt and line_cnt are tied to zero.
module netlist_comment_stripper
    import netlist_rd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             err_unterminated,
    output logic [CNT_W-1:0] comment_cnt,
    output logic [CNT_W-1:0] line_cnt
);

    localparam int FAW = $clog2(FIFO_DEPTH);

    strip_state_t state;
    strip_state_t nxt;
    logic         accept;
    logic         emit0;
    logic         emit1;
    logic [8:0]   ent0;
    logic [8:0]   ent1;
    logic         opened;
    logic         set_err;
    logic [8:0]   head;
    logic [FAW:0] free;

    // One beat may push two bytes ('/' plus the following byte), so only
    // accept when two slots are free.
    assign in_ready = (free >= (FAW+1)'(2));
    assign accept   = in_valid && in_ready;

    // Decode the current byte: what to emit, where to go next, side effects.
    always_comb begin
        nxt     = state;
        emit0   = 1'b0;
        emit1   = 1'b0;
        ent0    = '0;
        ent1    = '0;
        opened  = 1'b0;
        set_err = 1'b0;
        case (state)
            CODE: begin
                if (in_data == CH_SLASH) begin
                    if (in_last) begin
                        emit0 = 1'b1;
                        ent0  = make_entry(1'b1, CH_SLASH);
                    end else begin
                        nxt = SLASH;
                    end
                end else begin
                    emit0 = 1'b1;
                    ent0  = make_entry(in_last, in_data);
                end
            end
            SLASH: begin
                if (in_data == CH_SLASH || in_data == CH_STAR) begin
                    opened = 1'b1;
                    if (in_last) begin
                        emit0 = 1'b1;
                        ent0  = make_entry(1'b1, CH_SP);
                    end else begin
                        nxt = (in_data == CH_SLASH) ? LINE_C : BLOCK_C;
                    end
                end else begin
                    // The held slash was not a comment opener after all.
                    emit0 = 1'b1;
                    ent0  = make_entry(1'b0, CH_SLASH);
                    emit1 = 1'b1;
                    ent1  = make_entry(in_last, in_data);
                    nxt   = CODE;
                end
            end
            LINE_C: begin
                if (in_data == CH_NL) begin
                    emit0 = 1'b1;
                    ent0  = make_entry(in_last, CH_NL);
                    nxt   = CODE;
                end else if (in_last) begin
                    emit0 = 1'b1;
                    ent0  = make_entry(1'b1, CH_SP);
                end
            end
            BLOCK_C: begin
                if (in_data == CH_STAR) begin
                    nxt = BLOCK_STAR;
                end
                if (in_last) begin
                    emit0   = 1'b1;
                    ent0    = make_entry(1'b1, CH_SP);
                    set_err = 1'b1;
                end
            end
            BLOCK_STAR: begin
                if (in_data == CH_SLASH) begin
                    // A block comment collapses to one space.
                    emit0 = 1'b1;
                    ent0  = make_entry(in_last, CH_SP);
                    nxt   = CODE;
                end else begin
                    nxt = (in_data == CH_STAR) ? BLOCK_STAR : BLOCK_C;
                    if (in_last) begin
                        emit0   = 1'b1;
                        ent0    = make_entry(1'b1, CH_SP);
                        set_err = 1'b1;
                    end
                end
            end
            default: nxt = CODE;
        endcase
        if (in_last) begin
            nxt = CODE;
        end
    end

    // Stripper FSM and sticky unterminated-comment flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= CODE;
            err_unterminated <= 1'b0;
        end else if (accept) begin
            state <= nxt;
            if (set_err) begin
                err_unterminated <= 1'b1;
            end
        end
    end

`ifdef COMMENT_STATS_EN
    logic [CNT_W-1:0] comment_q;
    logic [CNT_W-1:0] line_q;

    // Saturating counts of comment openings and input newlines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comment_q <= '0;
            line_q    <= '0;
        end else if (accept) begin
            if (opened && comment_q != '1) begin
                comment_q <= comment_q + CNT_W'(1);
            end
            if (in_data == CH_NL && line_q != '1) begin
                line_q <= line_q + CNT_W'(1);
            end
        end
    end

    assign comment_cnt = comment_q;
    assign line_cnt    = line_q;
`else
    logic stats_unused;
    assign stats_unused = opened;
    assign comment_cnt  = '0;
    assign line_cnt     = '0;
`endif

    strip_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push0     (accept && emit0),
        .push1     (accept && emit1),
        .din0      (ent0),
        .din1      (ent1),
        .pop       (out_valid && out_ready),
        .dout      (head),
        .not_empty (out_valid),
        .free      (free)
    );

    assign out_data = head[7:0];
    assign out_last = head[8];

endmodule
